// File: rtl/ocm_pkg.sv
// Shared definitions for the on-chip-memory stream reader.
// Holds the memory geometry defaults and the reader FSM state type.
package ocm_pkg;

    localparam int OCM_ADDR_W     = 14;
    localparam int OCM_DATA_W     = 64;
    localparam int OCM_DEPTH      = 8960;
    localparam int OCM_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ocm_state_e;

endpackage

// File: rtl/ocm_rd_fifo.sv
// Show-ahead synchronous FIFO used as the output buffer of the stream reader.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             synchronous clear of all entries (wins over push/pop)
//   push_i/push_data_i  write one entry
//   pop_i               consume the head entry (caller only pops when !empty_o)
//   rd_data_o           head entry, zero while empty
//   empty_o, count_o    occupancy status
module ocm_rd_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (!push_i && pop_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; occupancy is tracked by the counters above.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ocm_stream_reader.sv
// Avalon-MM read initiator that plays a contiguous region of the on-chip
// sample memory out as a valid/ready stream, optionally looping.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start/abort                command pulses (abort has priority)
//   base_addr/num_words/loop   transfer arguments, latched on accepted start
//   busy/done/err              status; done and err are one-cycle pulses
//   mem_*                      Avalon-MM read port (fixed 1-cycle latency)
//   m_data/m_valid/m_ready     output stream
module ocm_stream_reader
    import ocm_pkg::*;
#(
    parameter int ADDR_W     = OCM_ADDR_W,
    parameter int DATA_W     = OCM_DATA_W,
    parameter int MEM_DEPTH  = OCM_DEPTH,
    parameter int FIFO_DEPTH = OCM_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       num_words,
    input  logic                  loop,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_WORDS = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);
    localparam logic [CNT_W:0]    FIFO_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    ocm_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     num_q, num_d;
    logic                loop_q, loop_d;
    logic                inflight_q, inflight_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                issue;
    logic                pop;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      occupancy;
    logic                can_issue;
    logic                args_bad;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    assign pop      = m_valid && m_ready;
    assign args_bad = ({1'b0, base_addr} >= DEPTH_WORDS) || (num_words > DEPTH_WORDS);

    // Credit check: words already buffered plus the one returning this cycle,
    // less the one leaving, must leave room for the read issued now.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign can_issue = pop ? (occupancy <= FIFO_LIMIT) : (occupancy < FIFO_LIMIT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        base_d  = base_q;
        num_d   = num_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        issue   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (args_bad) begin
                            err_d = 1'b1;
                        end else if (num_words == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            addr_d  = base_addr;
                            rem_d   = num_words;
                            base_d  = base_addr;
                            num_d   = num_words;
                            loop_d  = loop;
                        end
                    end
                end
                ST_RUN: begin
                    if (can_issue) begin
                        issue = 1'b1;
                        if (rem_q == REM_ONE) begin
                            // Looping restarts the pass seamlessly on the next read.
                            if (loop_q) begin
                                addr_d = base_q;
                                rem_d  = num_q;
                            end else begin
                                addr_d  = wrap_inc(addr_q);
                                rem_d   = '0;
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            addr_d = wrap_inc(addr_q);
                            rem_d  = rem_q - REM_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish as the final word is handed over, so done lands
                    // in the cycle right after that handshake.
                    if (!inflight_q && (fifo_count == {{(CNT_W-1){1'b0}}, pop})) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign inflight_d = issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            base_q     <= '0;
            num_q      <= '0;
            loop_q     <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            base_q     <= base_d;
            num_q      <= num_d;
            loop_q     <= loop_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // A word returning during an abort is dropped rather than buffered.
    ocm_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .flush_i     (abort),
        .push_i      (inflight_q && !abort),
        .push_data_i (mem_readdata),
        .pop_i       (pop),
        .rd_data_o   (m_data),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign m_valid        = !fifo_empty;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_ocm_stream_reader.sv
// Directed bench for ocm_stream_reader with a 1-cycle-latency memory model
// whose read data encodes the address, so word order is checkable.
module tb_ocm_stream_reader;

    localparam int AW  = 14;
    localparam int DW  = 64;
    localparam int DEP = 8960;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort, loop, m_ready;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          busy, done, err;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW/8-1:0] mem_byteenable;
    logic [DW-1:0] mem_readdata;
    logic [DW-1:0] m_data;
    logic          m_valid;

    ocm_stream_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .loop           (loop),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {16'hC0DE, 32'h0000_0000, 2'b00, a};
    endfunction

    // Memory port: data valid exactly one cycle after chipselect, junk otherwise.
    always @(posedge clk) begin
        mem_readdata <= mem_chipselect ? pat(mem_address) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    logic [AW-1:0] cs_addr[$];
    int            cs_cyc[$];
    logic [DW-1:0] hs_data[$];
    int            hs_cyc[$];
    int            done_cnt, err_cnt, done_cyc, first_valid_cyc;
    logic          done_busy;
    int            outstanding, max_out, stab_viol;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        cs_addr.delete(); cs_cyc.delete(); hs_data.delete(); hs_cyc.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        done_busy = 1'b1; outstanding = 0; max_out = 0; stab_viol = 0;
        prev_stall = 1'b0; prev_data = '0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_chipselect) begin
                cs_addr.push_back(mem_address);
                cs_cyc.push_back(cyc);
            end
            if (m_valid && m_ready) begin
                hs_data.push_back(m_data);
                hs_cyc.push_back(cyc);
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (err) err_cnt++;
            if (abort) outstanding = 0;
            else outstanding = outstanding + int'(mem_chipselect) - int'(m_valid && m_ready);
            if (outstanding > max_out) max_out = outstanding;
            if (prev_stall && m_valid && (m_data !== prev_data)) stab_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n, input logic lp, output int t0);
        tick();
        start = 1'b1; base_addr = b; num_words = (AW + 1)'(n); loop = lp;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_timeout"}, 64'(done_cnt > 0), 64'd1);
    endtask

    // Single non-loop pass with m_ready held high, plus a start pulse while busy
    // that must be ignored.
    task automatic run_pass(input logic [AW-1:0] b, input int n, input string tag);
        int t0;
        clear_mon();
        m_ready = 1'b1;
        tick();
        start = 1'b1; base_addr = b; num_words = (AW + 1)'(n); loop = 1'b0;
        t0 = cyc;
        tick();
        start = 1'b1; base_addr = 14'h0500; num_words = 15'd1;
        @(negedge clk);
        check_val({tag, "_busy_t1"}, 64'(busy), 64'd1);
        check_val({tag, "_cs_t1"}, 64'(mem_chipselect), 64'd1);
        tick();
        start = 1'b0;
        wait_done(n + 20, tag);
        repeat (3) tick();
        check_val({tag, "_ncs"}, 64'(cs_addr.size()), 64'(n));
        check_val({tag, "_nhs"}, 64'(hs_data.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ea;
            ea = AW'((int'(b) + i) % DEP);
            check_val({tag, "_addr"}, 64'(cs_addr[i]), 64'(ea));
            check_val({tag, "_cscyc"}, 64'(cs_cyc[i]), 64'(t0 + 1 + i));
            check_val({tag, "_data"}, hs_data[i], pat(ea));
        end
        check_val({tag, "_first_valid"}, 64'(first_valid_cyc), 64'(t0 + 3));
        check_val({tag, "_done_cyc"}, 64'(done_cyc), 64'(hs_cyc[n-1] + 1));
        check_val({tag, "_done_busy"}, 64'(done_busy), 64'd0);
        check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int t0;
        int n;
        int cs_at_abort;
        reset = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0; m_ready = 1'b0;
        base_addr = '0; num_words = '0;
        clear_mon();
        repeat (3) tick();
        @(negedge clk);
        check_val("rst_busy",  64'(busy), 64'd0);
        check_val("rst_done",  64'(done), 64'd0);
        check_val("rst_err",   64'(err), 64'd0);
        check_val("rst_valid", 64'(m_valid), 64'd0);
        check_val("rst_data",  m_data, 64'd0);
        check_val("rst_cs",    64'(mem_chipselect), 64'd0);
        check_val("rst_addr",  64'(mem_address), 64'd0);
        check_val("const_we",  64'(mem_write), 64'd0);
        check_val("const_be",  64'(mem_byteenable), 64'hFF);
        check_val("const_ce",  64'(mem_clken), 64'd1);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Basic pass and pass across the address wrap
        run_pass(14'h0010, 4, "basic");
        run_pass(14'd8958, 4, "wrap");

        // Backpressure: toggling ready then a long stall
        clear_mon();
        m_ready = 1'b0;
        do_start(14'd100, 8, 1'b0, t0);
        for (int k = 0; k < 80 && done_cnt == 0; k++) begin
            m_ready = (k < 8) ? (k % 2 == 0) : ((k < 18) ? 1'b0 : 1'b1);
            tick();
        end
        check_val("bp_timeout", 64'(done_cnt > 0), 64'd1);
        repeat (2) tick();
        check_val("bp_nhs", 64'(hs_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) check_val("bp_data", hs_data[i], pat(AW'(100 + i)));
        check_val("bp_ncs", 64'(cs_addr.size()), 64'd8);
        check_val("bp_max_buffered", 64'(max_out), 64'd4);
        check_val("bp_stable", 64'(stab_viol), 64'd0);
        check_val("bp_done_cnt", 64'(done_cnt), 64'd1);

        // Loop mode then abort
        clear_mon();
        m_ready = 1'b1;
        do_start(14'd5, 3, 1'b1, t0);
        n = 0;
        while (hs_data.size() < 12 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("loop_nhs", 64'(hs_data.size() >= 12), 64'd1);
        for (int i = 0; i < 12; i++) check_val("loop_data", hs_data[i], pat(AW'(5 + (i % 3))));
        check_val("loop_nogap", 64'(hs_cyc[11] - hs_cyc[0]), 64'd11);
        check_val("loop_first_valid", 64'(first_valid_cyc), 64'(t0 + 3));
        check_val("loop_busy", 64'(busy), 64'd1);
        tick();
        abort = 1'b1;
        @(negedge clk);
        check_val("abort_cs_low", 64'(mem_chipselect), 64'd0);
        cs_at_abort = cs_addr.size();
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_val("abort_valid", 64'(m_valid), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check_val("abort_valid_late", 64'(m_valid), 64'd0);
        check_val("abort_no_cs", 64'(cs_addr.size()), 64'(cs_at_abort));
        check_val("abort_no_done", 64'(done_cnt), 64'd0);

        // Illegal base address
        clear_mon();
        do_start(14'd9000, 4, 1'b0, t0);
        @(negedge clk);
        check_val("err_pulse", 64'(err), 64'd1);
        check_val("err_busy", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        check_val("err_pulse_end", 64'(err), 64'd0);
        check_val("err_no_cs", 64'(cs_addr.size()), 64'd0);

        // Illegal word count
        clear_mon();
        do_start(14'd0, 8961, 1'b0, t0);
        repeat (3) tick();
        check_val("errnum_cnt", 64'(err_cnt), 64'd1);
        check_val("errnum_no_cs", 64'(cs_addr.size()), 64'd0);
        check_val("errnum_busy", 64'(busy), 64'd0);

        // Zero-length pass
        clear_mon();
        do_start(14'd10, 0, 1'b0, t0);
        @(negedge clk);
        check_val("zero_done", 64'(done), 64'd1);
        check_val("zero_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check_val("zero_done_cnt", 64'(done_cnt), 64'd1);
        check_val("zero_no_cs", 64'(cs_addr.size()), 64'd0);

        // start and abort together in IDLE: abort wins
        clear_mon();
        tick();
        start = 1'b1; abort = 1'b1; base_addr = 14'd20; num_words = 15'd2; loop = 1'b0;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_val("sa_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check_val("sa_no_cs", 64'(cs_addr.size()), 64'd0);
        check_val("sa_no_done", 64'(done_cnt), 64'd0);

        // Abort the cycle after the first read issue, then restart
        clear_mon();
        m_ready = 1'b0;
        do_start(14'd200, 4, 1'b0, t0);
        @(negedge clk);
        check_val("ab1_cs", 64'(mem_chipselect), 64'd1);
        check_val("ab1_addr", 64'(mem_address), 64'd200);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_val("ab1_valid", 64'(m_valid), 64'd0);
        check_val("ab1_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check_val("ab1_valid_late", 64'(m_valid), 64'd0);
        check_val("ab1_ncs", 64'(cs_addr.size()), 64'd1);
        check_val("ab1_no_done", 64'(done_cnt), 64'd0);
        run_pass(14'd300, 2, "restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ocm_stream_reader.md
# ocm_stream_reader

Avalon-MM read initiator that drains a contiguous region of the dual-port on-chip sample memory (64-bit words, 8960 deep) and presents it as a valid/ready stream to the channel datapath. It sits on the memory's second port, so it can play out stored TX samples or channel taps while the NIOS side owns the first port. It issues single-word reads and absorbs the memory's fixed 1-cycle read latency. A small FIFO gives full backpressure tolerance without bubbles at 100% ready.

## Interface
- ADDR_W, 14, memory word-address width
- DATA_W, 64, memory/stream data width
- MEM_DEPTH, 8960, words in memory; address wrap point
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥2)

- clk  in  1  single clock, shared with memory port clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; latches base_addr/num_words/loop; ignored while busy
- abort  in  1  one-cycle pulse; stops transfer, flushes buffer
- base_addr  in  ADDR_W  first word address
- num_words  in  ADDR_W+1  words per pass (0..MEM_DEPTH)
- loop  in  1  1 = replay region until abort
- busy  out  1  high from start acceptance until done/abort/error
- done  out  1  one-cycle pulse after last word of a non-loop pass is accepted downstream
- err  out  1  one-cycle pulse: start with base_addr ≥ MEM_DEPTH or num_words > MEM_DEPTH
- mem_address  out  ADDR_W  read address
- mem_chipselect  out  1  read strobe, one word per cycle
- mem_write  out  1  constant 0
- mem_byteenable  out  DATA_W/8  constant all-ones
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  valid exactly 1 cycle after chipselect
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start with legal args and num_words ≠ 0 → RUN; addr ← base_addr, remaining ← num_words. num_words = 0 → done pulse next cycle, stay IDLE. Illegal args → err pulse next cycle, stay IDLE, busy stays 0.
- RUN: issue a read (chipselect = 1) when fifo_count + inflight + (pop ? −1 : 0) < FIFO_DEPTH. inflight is 0 or 1. On issue: addr ← (addr = MEM_DEPTH−1) ? 0 : addr+1; remaining −1.
- Issuing the last word: loop = 1 → addr ← base, remaining ← num_words, stay RUN (no done, no gap). loop = 0 → DRAIN.
- DRAIN: no reads; when inflight = 0 and FIFO empty → done pulse, IDLE.
- abort (any state, priority over start and issue): chipselect low same cycle; FIFO cleared; an in-flight word returning next cycle is discarded; → IDLE; no done.
- start while busy: ignored. start and abort same cycle in IDLE: abort wins, start ignored.
- Stream: m_valid = FIFO not empty; transfer on m_valid & m_ready; m_data holds stable while m_valid & !m_ready.
- Order: words emerge in address order, including across the wrap at MEM_DEPTH−1 → 0.

## Timing
- Reset values: busy 0, done 0, err 0, m_valid 0, m_data 0, mem_chipselect 0, mem_address 0; state IDLE; FIFO empty.
- start at cycle T → busy = 1 and first chipselect at T+1; readdata captured at T+2; m_valid = 1 at T+3.
- Sustained m_ready = 1: one word per cycle, no bubbles, including across loop restarts.
- m_ready low: at most FIFO_DEPTH words buffered; reads stop with no overflow and no data loss.
- done asserts the cycle after the final handshake; busy drops in the same cycle.

## Structure
- Package ocm_pkg: OCM_ADDR_W = 14, OCM_DATA_W = 64, OCM_DEPTH = 8960, state enum type.
- Sub-module ocm_rd_fifo: synchronous FIFO, show-ahead, with count output and a synchronous flush input. The top level holds the FSM, address/remaining counters, in-flight flag and credit logic.

## Test plan
- base 0x0010, num 4, m_ready = 1 → chipselect at addresses 0x10..0x13 on consecutive cycles; 4 words in order; m_valid first at T+3; done at the cycle after the 4th handshake.
- base 8958, num 4 → addresses 8958, 8959, 0, 1; data order preserved.
- num 8, m_ready toggling 1/0 and held low 10 cycles → never more than 4 words buffered; all 8 words delivered exactly once, in order.
- loop = 1, base 5, num 3, m_ready = 1 for 12 cycles → words 5, 6, 7 repeated 4 times with no gaps; abort → m_valid 0 next cycle, busy 0, no done.
- base 9000 → err pulse, busy stays 0, no chipselect; num 0 → done pulse, no reads.
- abort the cycle after a read issue → returned word discarded, FIFO empty; a new start afterwards works normally.
